// File: rtl/gfx_fb_writer_pkg.sv
// Shared width helpers for the framebuffer writer.
package gfx_fb_writer_pkg;

  localparam int unsigned H_WIDTH_DEF     = 12;
  localparam int unsigned V_WIDTH_DEF     = 12;
  localparam int unsigned PIXEL_WIDTH_DEF = 12;
  localparam int unsigned ADDR_WIDTH_DEF  = 20;

  // Full y*h+x product width before truncation to the address bus.
  function automatic int unsigned prod_width(input int unsigned h_w, input int unsigned v_w);
    return h_w + v_w;
  endfunction

endpackage

// File: rtl/gfx_fb_writer_pipe_reg.sv
// Generic single-entry valid/ready register slice.
module gfx_pipe_reg #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  out_ready
);

  assign in_ready = !out_valid || out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
    end else if (in_ready) begin
      out_valid <= in_valid;
      if (in_valid) out_data <= in_data;
    end
  end

endmodule

// File: rtl/gfx_fb_writer.sv
// Pixel stream sink: range-checks (x, y, pixel) beats and issues linear
// framebuffer writes at y*h_visible + x through a two-stage pipeline.
module gfx_fb_writer
  import gfx_fb_writer_pkg::*;
#(
  parameter int H_WIDTH     = H_WIDTH_DEF,
  parameter int V_WIDTH     = V_WIDTH_DEF,
  parameter int PIXEL_WIDTH = PIXEL_WIDTH_DEF,
  parameter int ADDR_WIDTH  = ADDR_WIDTH_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   s_gfx_valid,
  input  logic [H_WIDTH-1:0]     s_gfx_x,
  input  logic [V_WIDTH-1:0]     s_gfx_y,
  input  logic [PIXEL_WIDTH-1:0] s_gfx_pixel,
  output logic                   s_gfx_ready,
  output logic                   m_mem_valid,
  output logic [ADDR_WIDTH-1:0]  m_mem_addr,
  output logic [PIXEL_WIDTH-1:0] m_mem_data,
  input  logic                   m_mem_ready,
  input  logic [H_WIDTH-1:0]     h_visible,
  input  logic [V_WIDTH-1:0]     v_visible,
  output logic                   frame_done,
  output logic                   oob_drop
);

  localparam int PROD_W = int'(prod_width(H_WIDTH, V_WIDTH));
  localparam int A_W    = 2 + PIXEL_WIDTH + H_WIDTH + V_WIDTH;
  localparam int B_W    = 1 + PIXEL_WIDTH + ADDR_WIDTH;

  logic                   in_range_d;
  logic                   last_d;
  logic [A_W-1:0]         a_in_data;
  logic                   a_in_ready;
  logic                   a_valid;
  logic [A_W-1:0]         a_data;
  logic                   a_out_ready;
  logic                   a_in_range;
  logic                   a_last;
  logic [PIXEL_WIDTH-1:0] a_pixel;
  logic [H_WIDTH-1:0]     a_x;
  logic [V_WIDTH-1:0]     a_y;
  logic [PROD_W-1:0]      full_addr;
  logic                   b_in_valid;
  logic                   b_in_ready;
  logic [B_W-1:0]         b_in_data;
  logic [B_W-1:0]         b_data;
  logic                   b_last;

  // With h_visible==0 the last compare can alias, but in_range masks it.
  assign in_range_d = (s_gfx_x < h_visible) && (s_gfx_y < v_visible);
  assign last_d     = (s_gfx_x == h_visible - H_WIDTH'(1)) &&
                      (s_gfx_y == v_visible - V_WIDTH'(1));
  assign a_in_data  = {last_d, in_range_d, s_gfx_pixel, s_gfx_x, s_gfx_y};

  assign s_gfx_ready = a_in_ready && !rst;

  gfx_pipe_reg #(.DATA_WIDTH(A_W)) u_stage_a (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (s_gfx_valid),
    .in_data   (a_in_data),
    .in_ready  (a_in_ready),
    .out_valid (a_valid),
    .out_data  (a_data),
    .out_ready (a_out_ready)
  );

  assign {a_last, a_in_range, a_pixel, a_x, a_y} = a_data;

  // Out-of-range beats leave stage A without needing room in stage B.
  assign a_out_ready = b_in_ready || !a_in_range;
  assign b_in_valid  = a_valid && a_in_range;
  assign full_addr   = PROD_W'(a_y) * PROD_W'(h_visible) + PROD_W'(a_x);
  assign b_in_data   = {a_last, a_pixel, ADDR_WIDTH'(full_addr)};

  gfx_pipe_reg #(.DATA_WIDTH(B_W)) u_stage_b (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (b_in_valid),
    .in_data   (b_in_data),
    .in_ready  (b_in_ready),
    .out_valid (m_mem_valid),
    .out_data  (b_data),
    .out_ready (m_mem_ready)
  );

  assign {b_last, m_mem_data, m_mem_addr} = b_data;

  assign oob_drop = a_valid && !a_in_range && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_done <= 1'b0;
    end else begin
      frame_done <= m_mem_valid && m_mem_ready && b_last;
    end
  end

endmodule
